// File: rtl/grid_readout_pkg.sv
// Shared gridding constants: default tile geometry and the completed-tile counter width.
package grid_readout_pkg;

  localparam int WORD_W_DEF = 64;
  localparam int BEATS_DEF  = 32;
  localparam int TAG_W_DEF  = 32;
  localparam int TILE_W_DEF = WORD_W_DEF * BEATS_DEF;
  localparam int DONE_W     = 16;

  // Beat counter width; a single-beat tile still needs one bit.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/grid_tile_shifter.sv
// Tile shifter: holds one tile being drained MSB-first, one WORD_W beat per advance.
module grid_tile_shifter
  import grid_readout_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BEATS  = BEATS_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic [WORD_W*BEATS-1:0]   load_data_i,
  input  logic [TAG_W-1:0]          load_tag_i,
  input  logic                      advance_i,
  output logic                      valid_o,
  output logic [WORD_W-1:0]         word_o,
  output logic [TAG_W-1:0]          tag_o,
  output logic                      last_beat_o
);

  localparam int TILE_W = WORD_W * BEATS;
  localparam int BEAT_W = beat_width(BEATS);

  logic [TILE_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              valid_q, valid_d;

  assign last_beat_o = (beat_q == BEAT_W'(BEATS - 1));

  // A load wins over an advance so the last beat of one tile can hand straight to the next.
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = load_data_i;
      tag_d   = load_tag_i;
      beat_d  = '0;
      valid_d = 1'b1;
    end else if (advance_i) begin
      data_d = data_q << WORD_W;
      if (last_beat_o) begin
        beat_d  = '0;
        valid_d = 1'b0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = data_q[TILE_W-1 -: WORD_W];
  assign tag_o   = tag_q;

endmodule

// File: rtl/grid_readout_ctrl.sv
// Grid tile readout: a one-tile hold slot in front of a shifter that streams WORD_W beats.
module grid_readout_ctrl
  import grid_readout_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BEATS  = BEATS_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_W*BEATS-1:0]  tile_data,
  input  logic [TAG_W-1:0]         tile_tag,
  input  logic                     tile_valid,
  output logic                     tile_ready,
  input  logic                     drain_en,
  output logic [WORD_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic [DONE_W-1:0]        tiles_done
);

  // Handshakes: a tile moves when tile_valid && tile_ready at a rising edge; a word moves
  // when out_valid && out_ready at a rising edge. tile_ready depends on registered state only.

  localparam int TILE_W = WORD_W * BEATS;

  logic [TILE_W-1:0] hold_data_q, hold_data_d;
  logic [TAG_W-1:0]  hold_tag_q, hold_tag_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DONE_W-1:0] done_q, done_d;

  logic shift_valid;
  logic last_beat;
  logic accept;
  logic xfer;
  logic last_xfer;
  logic load;

  assign tile_ready = rst & ~hold_valid_q;
  assign accept     = tile_valid & tile_ready;
  assign out_valid  = shift_valid & drain_en;
  assign xfer       = out_valid & out_ready;
  assign last_xfer  = xfer & last_beat;
  assign load       = hold_valid_q & (~shift_valid | last_xfer);
  assign out_last   = out_valid & last_beat;
  assign busy       = hold_valid_q | shift_valid;
  assign tiles_done = done_q;

  // accept and load are mutually exclusive: accept needs an empty slot, load a full one.
  always_comb begin
    hold_data_d  = hold_data_q;
    hold_tag_d   = hold_tag_q;
    hold_valid_d = hold_valid_q;
    done_d       = done_q;
    if (accept) begin
      hold_data_d  = tile_data;
      hold_tag_d   = tile_tag;
      hold_valid_d = 1'b1;
    end else if (load) begin
      hold_valid_d = 1'b0;
    end
    if (last_xfer) begin
      done_d = done_q + DONE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data_q  <= '0;
      hold_tag_q   <= '0;
      hold_valid_q <= 1'b0;
      done_q       <= '0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_tag_q   <= hold_tag_d;
      hold_valid_q <= hold_valid_d;
      done_q       <= done_d;
    end
  end

  grid_tile_shifter #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS),
    .TAG_W  (TAG_W)
  ) u_shifter (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_i      (load),
    .load_data_i (hold_data_q),
    .load_tag_i  (hold_tag_q),
    .advance_i   (xfer),
    .valid_o     (shift_valid),
    .word_o      (out_data),
    .tag_o       (out_tag),
    .last_beat_o (last_beat)
  );

endmodule

// File: doc/grid_readout_ctrl.md
GRID_READOUT_CTRL -- requirements
Module: grid_readout_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_W, default 64: output word width in bits.
REQ-002 The block SHALL have parameter BEATS, default 32: words per tile; TILE_W = WORD_W*BEATS, 2048 by default.
REQ-003 The block SHALL have parameter TAG_W, default 32: width of the grid-index tag.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port tile_data, input, TILE_W bits: accumulated grid tile.
REQ-007 The block SHALL have port tile_tag, input, TAG_W bits: grid index of the tile.
REQ-008 The block SHALL have port tile_valid, input, 1 bit: tile offered.
REQ-009 The block SHALL have port tile_ready, output, 1 bit: tile accepted when tile_valid and tile_ready are both high.
REQ-010 The block SHALL have port drain_en, input, 1 bit: readout enable; low freezes the output stream.
REQ-011 The block SHALL have port out_data, output, WORD_W bits: current word.
REQ-012 The block SHALL have port out_tag, output, TAG_W bits: tag of the tile being drained.
REQ-013 The block SHALL have port out_valid, output, 1 bit: word valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts; a beat transfers when out_valid and out_ready are both high.
REQ-015 The block SHALL have port out_last, output, 1 bit: marks the final word of a tile.
REQ-016 The block SHALL have port busy, output, 1 bit: a tile is held or being drained.
REQ-017 The block SHALL have port tiles_done, output, 16 bits: completed-tile count, wraps modulo 2^16.

Function
REQ-018 Storage SHALL be two entries: a hold slot (hold_valid, data, tag) and a shifter (shift_valid, data, tag, beat counter 0..BEATS-1).
REQ-019 tile_ready SHALL equal (rst high) AND NOT hold_valid; it is a registered-state function only, with no combinational path from out_ready.
REQ-020 An accepted tile SHALL be written to the hold slot, and hold_valid SHALL set on the same edge.
REQ-021 The shifter SHALL load from the hold slot, and hold_valid SHALL clear, on an edge where hold_valid=1 and (shift_valid=0 or a last-beat transfer occurs); the beat counter SHALL reset to 0 on load.
REQ-022 Accepting a new tile and loading the held tile on the same edge SHALL be impossible, because tile_ready is 0 whenever hold_valid=1.
REQ-023 out_valid SHALL equal shift_valid AND drain_en.
REQ-024 out_data SHALL be the top WORD_W bits of the shifter, so bits [TILE_W-1 -: WORD_W] are emitted first, MSB-first.
REQ-025 out_last SHALL equal out_valid AND (beat == BEATS-1).
REQ-026 On each beat transfer the shifter SHALL shift left by WORD_W and the beat counter SHALL increment.
REQ-027 On a last-beat transfer: if the hold slot is full, the shifter SHALL reload with no bubble; otherwise shift_valid SHALL clear. In both cases tiles_done SHALL increment by 1.
REQ-028 With out_valid=1 and out_ready=0, out_data, out_tag and out_last SHALL remain stable.
REQ-029 With drain_en=0, no beat SHALL advance; hold acceptance and the shifter load from an empty shifter SHALL still occur.
REQ-030 Latency SHALL be as follows: tile accepted at edge N with both entries empty gives first out_valid after edge N+1; steady state is BEATS beats per tile with zero idle cycles.
REQ-031 busy SHALL equal hold_valid OR shift_valid.

Reset
REQ-032 When rst is low, hold_valid, shift_valid, beat, tiles_done, and the data and tag registers SHALL clear to 0 asynchronously.
REQ-033 During reset, out_valid, out_last, busy and tile_ready SHALL be 0 and out_data SHALL be 0.
REQ-034 A reset asserted mid-tile SHALL discard both entries; after release, operation SHALL resume from empty with no partial tile emitted.

Structure
REQ-035 WORD_W, BEATS, TAG_W defaults and the derived TILE_W, plus the tiles_done width of 16, SHALL reside in the shared gridding constants package.
REQ-036 A single sub-module grid_tile_shifter SHALL hold the shifter data, tag, beat counter and shift/load controls; hold-slot and handshake logic SHALL stay in the top level.

Verification
REQ-037 Single tile: data words k = 64'h0000_0000_0000_00kk for k=0..31, MSB-first, with tag 32'hA5, out_ready=1 and drain_en=1; the bench SHALL check 32 beats in order 0..31, out_last only on beat 31, out_tag=32'hA5, and tiles_done=1.
REQ-038 Back-to-back: the bench SHALL offer three tiles continuously and check 96 consecutive out_valid cycles with no gap and tiles_done=3.
REQ-039 Backpressure: the bench SHALL toggle out_ready with pattern 1,0,0,1 and check that held words stay stable, that exactly 32 transfers occur, and that tile_ready stays 0 while the hold slot is full.
REQ-040 drain_en: the bench SHALL drop drain_en at beat 10 for 5 cycles and check out_valid=0 and beat count frozen, then resumption at beat 10.
REQ-041 Reset mid-tile: the bench SHALL assert rst at beat 17 with the hold slot full and check busy=0, tiles_done=0 and out_valid=0; a new tile afterwards SHALL start at beat 0.
REQ-042 Wrap: the bench SHALL preload or force tiles_done=16'hFFFF, complete one tile, and check tiles_done=0.
